// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM request arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    DL  = 2'd0,
    FBW = 2'd1,
    FBR = 2'd2
  } req_id_e;

  localparam int AGE_LIMIT_DEF = 16;

endpackage

// File: rtl/sdram_arb_prio.sv
// Combinational winner select: promoted framebuffer clients first, then fixed dl > fbw > fbr.
module sdram_arb_prio (
  input  logic [2:0] req_i,      // {fbr, fbw, dl}
  input  logic [1:0] promote_i,  // {fbr, fbw}
  output logic [2:0] grant_o     // one-hot {fbr, fbw, dl}
);

  always_comb begin
    grant_o = 3'b000;
    if (req_i[1] && promote_i[0]) begin
      grant_o = 3'b010;
    end else if (req_i[2] && promote_i[1]) begin
      grant_o = 3'b100;
    end else if (req_i[0]) begin
      grant_o = 3'b001;
    end else if (req_i[1]) begin
      grant_o = 3'b010;
    end else if (req_i[2]) begin
      grant_o = 3'b100;
    end else begin
      grant_o = 3'b000;
    end
  end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Three-client SDRAM command arbiter (download write, framebuffer write, framebuffer read).
// Define SDRAM_ARB_AGE_BOOST_EN to add age-based starvation protection for fbw/fbr.
module sdram_req_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 16,
  parameter int AGE_LIMIT = AGE_LIMIT_DEF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              dl_req,
  input  logic              fbw_req,
  input  logic              fbr_req,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [ADDR_W-1:0] fbw_addr,
  input  logic [ADDR_W-1:0] fbr_addr,
  input  logic [DATA_W-1:0] dl_wdata,
  input  logic [DATA_W-1:0] fbw_wdata,
  output logic              dl_ack,
  output logic              fbw_ack,
  output logic              fbr_ack,
  output logic [DATA_W-1:0] fbr_rdata,
  output logic              fbr_rvalid,
  output logic              cmd_valid,
  output logic              cmd_we,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  input  logic              cmd_ready,
  input  logic              sd_rvalid,
  input  logic [DATA_W-1:0] sd_rdata,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  req_id_e           id_q, id_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [2:0]        grant_s;
  logic [1:0]        promote_s;
  logic              accept_s;

  assign accept_s = cmd_valid_q && cmd_ready;
  assign dl_ack   = accept_s && (id_q == DL);
  assign fbw_ack  = accept_s && (id_q == FBW);
  assign fbr_ack  = accept_s && (id_q == FBR);

`ifdef SDRAM_ARB_AGE_BOOST_EN
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

  logic [AGE_W-1:0] fbw_age_q, fbw_age_d, fbr_age_q, fbr_age_d;

  function automatic logic [AGE_W-1:0] age_next(input logic waiting, input logic [AGE_W-1:0] age);
    if (!waiting) begin
      return {AGE_W{1'b0}};
    end else if (age >= AGE_MAX) begin
      return age;
    end else begin
      return age + 1'b1;
    end
  endfunction

  always_comb begin
    fbw_age_d = age_next(fbw_req && !fbw_ack, fbw_age_q);
    fbr_age_d = age_next(fbr_req && !fbr_ack, fbr_age_q);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      fbw_age_q <= {AGE_W{1'b0}};
      fbr_age_q <= {AGE_W{1'b0}};
    end else begin
      fbw_age_q <= fbw_age_d;
      fbr_age_q <= fbr_age_d;
    end
  end

  assign promote_s = {fbr_age_q >= AGE_MAX, fbw_age_q >= AGE_MAX};
`else
  assign promote_s = 2'b00;
`endif

  sdram_arb_prio u_prio (
    .req_i     ({fbr_req, fbw_req, dl_req}),
    .promote_i (promote_s),
    .grant_o   (grant_s)
  );

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    cmd_valid_d = cmd_valid_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rvalid_d    = 1'b0;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_s != 3'b000) begin
          state_d     = ISSUE;
          cmd_valid_d = 1'b1;
          if (grant_s[0]) begin
            id_d        = DL;
            cmd_we_d    = 1'b1;
            cmd_addr_d  = dl_addr;
            cmd_wdata_d = dl_wdata;
          end else if (grant_s[1]) begin
            id_d        = FBW;
            cmd_we_d    = 1'b1;
            cmd_addr_d  = fbw_addr;
            cmd_wdata_d = fbw_wdata;
          end else begin
            id_d        = FBR;
            cmd_we_d    = 1'b0;
            cmd_addr_d  = fbr_addr;
            cmd_wdata_d = {DATA_W{1'b0}};
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = (id_q == FBR) ? WAIT_RD : IDLE;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT_RD: begin
        // Only the first return after a read command is forwarded.
        if (sd_rvalid) begin
          rvalid_d = 1'b1;
          rdata_d  = sd_rdata;
          state_d  = IDLE;
        end else begin
          state_d = WAIT_RD;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      id_q        <= DL;
      cmd_valid_q <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= {ADDR_W{1'b0}};
      cmd_wdata_q <= {DATA_W{1'b0}};
      rvalid_q    <= 1'b0;
      rdata_q     <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_we     = cmd_we_q;
  assign cmd_addr   = cmd_addr_q;
  assign cmd_wdata  = cmd_wdata_q;
  assign fbr_rvalid = rvalid_q;
  assign fbr_rdata  = rdata_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Randomized bench for sdram_req_arbiter against a transaction-level reference model.
module tb_sdram_req_arbiter;

  localparam int AW  = 25;
  localparam int DW  = 16;
  localparam int AGE = 16;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          dl_req, fbw_req, fbr_req;
  logic [AW-1:0] dl_addr, fbw_addr, fbr_addr;
  logic [DW-1:0] dl_wdata, fbw_wdata;
  logic          dl_ack, fbw_ack, fbr_ack;
  logic [DW-1:0] fbr_rdata;
  logic          fbr_rvalid;
  logic          cmd_valid, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          cmd_ready;
  logic          sd_rvalid;
  logic [DW-1:0] sd_rdata;
  logic          busy;

  sdram_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .AGE_LIMIT(AGE)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .dl_req(dl_req), .fbw_req(fbw_req), .fbr_req(fbr_req),
    .dl_addr(dl_addr), .fbw_addr(fbw_addr), .fbr_addr(fbr_addr),
    .dl_wdata(dl_wdata), .fbw_wdata(fbw_wdata),
    .dl_ack(dl_ack), .fbw_ack(fbw_ack), .fbr_ack(fbr_ack),
    .fbr_rdata(fbr_rdata), .fbr_rvalid(fbr_rvalid),
    .cmd_valid(cmd_valid), .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_ready(cmd_ready), .sd_rvalid(sd_rvalid), .sd_rdata(sd_rdata), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  // Client-side request state: index 0 = dl, 1 = fbw, 2 = fbr.
  logic          c_req [3];
  logic [AW-1:0] c_addr[3];
  logic [DW-1:0] c_data[3];

  // Reference model: phase 0 = no command, 1 = command offered, 2 = read outstanding.
  int            m_phase;
  int            m_who;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_rv;
  logic [DW-1:0] m_rdata;
  int            m_age[3];

  logic [2:0]    last_ack;
  int            n_ack[3];
  int            n_rv;
  int            q_order[$];
  int            vectors = 0;
  int            errors  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_who = 0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    m_rv = 1'b0; m_rdata = '0;
    for (int i = 0; i < 3; i++) m_age[i] = 0;
  endtask

  // Winner by the arbitration rules: starved framebuffer clients first (fbw before fbr), else dl, fbw, fbr.
  function automatic int pick();
`ifdef SDRAM_ARB_AGE_BOOST_EN
    if (c_req[1] && m_age[1] >= AGE) return 1;
    if (c_req[2] && m_age[2] >= AGE) return 2;
`endif
    for (int i = 0; i < 3; i++) if (c_req[i]) return i;
    return -1;
  endfunction

  task automatic drive();
    dl_req  = c_req[0]; dl_addr  = c_addr[0]; dl_wdata  = c_data[0];
    fbw_req = c_req[1]; fbw_addr = c_addr[1]; fbw_wdata = c_data[1];
    fbr_req = c_req[2]; fbr_addr = c_addr[2];
  endtask

  // One clock: apply inputs, compare outputs with the model, advance the model across the edge.
  task automatic cycle();
    logic [2:0] exp_ack;
    int win;
    drive();
    #1;
    if (reset) begin
      model_reset();
      check_eq("rst_cmd_we", 64'(cmd_we), 64'(0));
      check_eq("rst_cmd_addr", 64'(cmd_addr), 64'(0));
      check_eq("rst_cmd_wdata", 64'(cmd_wdata), 64'(0));
      check_eq("rst_fbr_rdata", 64'(fbr_rdata), 64'(0));
    end
    exp_ack = 3'b000;
    if (m_phase == 1 && cmd_ready) exp_ack[m_who] = 1'b1;
    check_eq("cmd_valid", 64'(cmd_valid), 64'(m_phase == 1));
    check_eq("busy", 64'(busy), 64'(m_phase != 0));
    check_eq("acks", 64'({fbr_ack, fbw_ack, dl_ack}), 64'(exp_ack));
    check_eq("fbr_rvalid", 64'(fbr_rvalid), 64'(m_rv));
    if (m_rv) check_eq("fbr_rdata", 64'(fbr_rdata), 64'(m_rdata));
    if (m_phase == 1) begin
      check_eq("cmd_we", 64'(cmd_we), 64'(m_we));
      check_eq("cmd_addr", 64'(cmd_addr), 64'(m_addr));
      if (m_we) check_eq("cmd_wdata", 64'(cmd_wdata), 64'(m_wdata));
    end
    if (dl_ack)  begin n_ack[0]++; q_order.push_back(0); end
    if (fbw_ack) begin n_ack[1]++; q_order.push_back(1); end
    if (fbr_ack) begin n_ack[2]++; q_order.push_back(2); end
    if (fbr_rvalid) n_rv++;
    last_ack = exp_ack;
    if (!reset) begin
      m_rv = 1'b0;
      case (m_phase)
        0: begin
          win = pick();
          if (win >= 0) begin
            m_phase = 1; m_who = win; m_we = (win != 2);
            m_addr = c_addr[win]; m_wdata = c_data[win];
          end
        end
        1: if (cmd_ready) m_phase = (m_who == 2) ? 2 : 0;
        default: if (sd_rvalid) begin m_rv = 1'b1; m_rdata = sd_rdata; m_phase = 0; end
      endcase
      for (int i = 1; i < 3; i++) m_age[i] = (c_req[i] && !exp_ack[i]) ? m_age[i] + 1 : 0;
    end
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic drop_acked();
    for (int i = 0; i < 3; i++) if (last_ack[i]) c_req[i] = 1'b0;
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 3; i++) n_ack[i] = 0;
    n_rv = 0;
    q_order.delete();
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) c_req[i] = 1'b0;
    cmd_ready = 1'b1; sd_rvalid = 1'b1; sd_rdata = 16'h0F0F;
    repeat (4) cycle();
    sd_rvalid = 1'b0;
    repeat (2) cycle();
  endtask

  int ack_at;

  initial begin
    for (int i = 0; i < 3; i++) begin c_req[i] = 1'b0; c_addr[i] = '0; c_data[i] = '0; end
    reset = 1'b1; cmd_ready = 1'b0; sd_rvalid = 1'b0; sd_rdata = '0;
    last_ack = 3'b000;
    model_reset(); clear_obs(); drive();
    @(negedge clk_sys);
    repeat (2) cycle();
    reset = 1'b0;

    // Test 1: single download write.
    clear_obs();
    c_req[0] = 1'b1; c_addr[0] = 25'h000100; c_data[0] = 16'hA55A; cmd_ready = 1'b1;
    repeat (5) begin cycle(); drop_acked(); end
    check_eq("t1_dl_ack_pulses", 64'(n_ack[0]), 64'(1));

    // Test 2: simultaneous requests, fixed priority order.
    clear_obs();
    c_req[0] = 1'b1; c_addr[0] = 25'h0000AA; c_data[0] = 16'h1111;
    c_req[1] = 1'b1; c_addr[1] = 25'h0000BB; c_data[1] = 16'h2222;
    c_req[2] = 1'b1; c_addr[2] = 25'h0000CC;
    repeat (6) begin cycle(); drop_acked(); end
    sd_rvalid = 1'b1; sd_rdata = 16'h5A5A; cycle(); sd_rvalid = 1'b0;
    repeat (2) cycle();
    check_eq("t2_order_len", 64'(q_order.size()), 64'(3));
    for (int i = 0; i < 3; i++)
      check_eq("t2_order", 64'((q_order.size() > i) ? q_order[i] : 99), 64'(i));

    // Test 3: framebuffer read with delayed return, then a stray return while idle.
    clear_obs();
    c_req[2] = 1'b1; c_addr[2] = 25'h1F0000;
    cycle(); cycle(); drop_acked();
    repeat (4) cycle();
    sd_rvalid = 1'b1; sd_rdata = 16'h1234; cycle();
    sd_rvalid = 1'b0; cycle();
    check_eq("t3_rdata", 64'(fbr_rdata), 64'(16'h1234));
    sd_rvalid = 1'b1; sd_rdata = 16'hBEEF; cycle();
    sd_rvalid = 1'b0; repeat (2) cycle();
    check_eq("t3_rvalid_pulses", 64'(n_rv), 64'(1));
    check_eq("t3_rdata_held", 64'(fbr_rdata), 64'(16'h1234));

    // Test 4: controller back-pressure holds the command.
    clear_obs();
    cmd_ready = 1'b0;
    c_req[0] = 1'b1; c_addr[0] = 25'h0ABCDE; c_data[0] = 16'hC3C3;
    repeat (11) cycle();
    check_eq("t4_no_ack", 64'(n_ack[0] + n_ack[1] + n_ack[2]), 64'(0));
    check_eq("t4_busy", 64'(busy), 64'(1));
    cmd_ready = 1'b1;
    cycle(); drop_acked();
    repeat (2) cycle();
    check_eq("t4_ack_after_ready", 64'(n_ack[0]), 64'(1));

    // Test 5: dl held continuously alongside an fbr read.
    clear_obs();
    ack_at = -1;
    c_req[0] = 1'b1; c_addr[0] = 25'h000010; c_data[0] = 16'h7777;
    c_req[2] = 1'b1; c_addr[2] = 25'h000020;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (last_ack[2]) c_req[2] = 1'b0;
      if (ack_at < 0 && n_ack[2] != 0) ack_at = k;
    end
`ifdef SDRAM_ARB_AGE_BOOST_EN
    check_eq("t5_fbr_ack_cycle", 64'(ack_at), 64'(17));
`else
    check_eq("t5_fbr_ack_cycle", 64'(ack_at), 64'(-1));
`endif
    drain();

    // Test 6: reset while a read is outstanding, then a late return.
    c_req[2] = 1'b1; c_addr[2] = 25'h155555;
    cycle(); cycle(); drop_acked(); cycle();
    clear_obs();
    reset = 1'b1; repeat (2) cycle();
    reset = 1'b0;
    sd_rvalid = 1'b1; sd_rdata = 16'hDEAD; cycle();
    sd_rvalid = 1'b0; repeat (2) cycle();
    check_eq("t6_no_rvalid", 64'(n_rv), 64'(0));
    check_eq("t6_no_ack", 64'(n_ack[0] + n_ack[1] + n_ack[2]), 64'(0));
    check_eq("t6_rdata_reset", 64'(fbr_rdata), 64'(0));

    // Randomized traffic with back-pressure, stray returns and abandoned requests.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (last_ack[i]) c_req[i] = 1'b0;
        else if (!c_req[i] && ($urandom % 3 == 0)) begin
          c_req[i] = 1'b1; c_addr[i] = AW'($urandom); c_data[i] = DW'($urandom);
        end else if (c_req[i] && ($urandom % 50 == 0)) c_req[i] = 1'b0;
      end
      cmd_ready = ($urandom % 10) < 7;
      sd_rvalid = ($urandom % 4) == 0;
      sd_rdata  = DW'($urandom);
      cycle();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
